// File: rtl/osc_pkg.sv
// Shared oscilloscope definitions: acquisition FSM encoding,
// trigger slope codes and the default sample/record geometry.
package osc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    WAIT_TRIG,
    POSTTRIG,
    DONE
  } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample memory: synchronous write port and
// registered read port whose output register clears on reset.
module capture_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trig_capture.sv
// Triggered acquisition: circular sample record frozen around a
// level/slope trigger, read back oldest-first.
module trig_capture
  import osc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PRE     = 64,
  parameter int AUTO_TO = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              auto_mode,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              auto_trig
);

  localparam int POST = DEPTH - PRE - 1;
  localparam int TO_W = $clog2(AUTO_TO + 1);

  state_t state, state_nx;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] start_ptr;
  logic [ADDR_W-1:0] cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] prev_sample;
  logic              prev_valid;

  logic strobe;
  logic real_trig;
  logic timeout;
  logic last_pre;
  logic last_post;
  logic start_arm;
  logic trig_hit;
  logic finish;

  assign busy = (state == PRETRIG) || (state == WAIT_TRIG) ||
                (state == POSTTRIG);
  assign done = (state == DONE);

  assign strobe = sample_en && busy;

  always_comb begin
    real_trig = 1'b0;
    if (prev_valid) begin
      if (trig_slope == SLOPE_FALL)
        real_trig = (prev_sample > trig_level) &&
                    (adc_data <= trig_level);
      else
        real_trig = (prev_sample < trig_level) &&
                    (adc_data >= trig_level);
    end
  end

  // to_cnt saturates, so ">=" also covers auto_mode raised late
  assign timeout   = auto_mode && (to_cnt >= TO_W'(AUTO_TO - 1));
  assign last_pre  = (cnt == ADDR_W'(PRE - 1));
  assign last_post = (cnt == ADDR_W'(POST - 1));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_arm = 1'b0;
    trig_hit  = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (arm) begin
          state_nx  = PRETRIG;
          start_arm = 1'b1;
        end
      end
      PRETRIG: begin
        if (sample_en && last_pre) state_nx = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (sample_en && (real_trig || timeout)) begin
          trig_hit = 1'b1;
          if (POST == 0) begin
            state_nx = DONE;
            finish   = 1'b1;
          end else begin
            state_nx = POSTTRIG;
          end
        end
      end
      POSTTRIG: begin
        if (sample_en && last_post) begin
          state_nx = DONE;
          finish   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      start_ptr   <= '0;
      cnt         <= '0;
      to_cnt      <= '0;
      prev_sample <= '0;
      prev_valid  <= 1'b0;
      auto_trig   <= 1'b0;
    end else begin
      if (start_arm) begin
        cnt        <= '0;
        to_cnt     <= '0;
        prev_valid <= 1'b0;
        auto_trig  <= 1'b0;
      end
      if (strobe) begin
        wr_ptr      <= wr_ptr + 1'b1;
        prev_sample <= adc_data;
        prev_valid  <= 1'b1;
      end
      if (strobe && state == PRETRIG)
        cnt <= last_pre ? '0 : cnt + 1'b1;
      else if (strobe && state == POSTTRIG)
        cnt <= cnt + 1'b1;
      if (strobe && state == WAIT_TRIG &&
          to_cnt != TO_W'(AUTO_TO))
        to_cnt <= to_cnt + 1'b1;
      if (trig_hit) auto_trig <= !real_trig;
      // wr_ptr+1 is the oldest surviving sample after the last write
      if (finish) start_ptr <= wr_ptr + 1'b1;
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk_in),
    .rst     (rst),
    .we      (strobe),
    .wr_addr (wr_ptr),
    .wr_data (adc_data),
    .rd_addr (start_ptr + rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_trig_capture.sv
// Randomised bench for trig_capture: a stream-level model predicts
// trigger position, record contents and completion strobe count.
module tb_trig_capture;

  localparam int DW      = 8;
  localparam int DEPTH   = 256;
  localparam int PRE     = 64;
  localparam int AUTO_TO = 1024;
  localparam int AW      = 8;
  localparam int MAXN    = 1500;

  logic          clk_in = 1'b0;
  logic          rst = 1'b0;
  logic          sample_en = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          arm = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          trig_slope = 1'b0;
  logic          auto_mode = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          auto_trig;

  int checks = 0;
  int errors = 0;
  int s [MAXN];
  int nstr;

  always #5 clk_in = ~clk_in;

  trig_capture #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .PRE     (PRE),
    .AUTO_TO (AUTO_TO)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .sample_en  (sample_en),
    .adc_data   (adc_data),
    .arm        (arm),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
    .auto_mode  (auto_mode),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .auto_trig  (auto_trig)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic strobe(input int v, input int gap);
    sample_en = 1'b1;
    adc_data  = DW'(v);
    @(negedge clk_in);
    sample_en = 1'b0;
    adc_data  = DW'($urandom);
    repeat (gap) @(negedge clk_in);
  endtask

  task automatic rd_chk(input string tag, input int a, input int exp);
    rd_addr = AW'(a);
    @(negedge clk_in);
    chk(tag, 32'(rd_data), exp);
  endtask

  // mode 0: ramp, 1: constant 50, 2: uniform random
  task automatic run(input string tag, input int mode, input int lvl,
                     input int slope, input int am, input int gapmax,
                     input int coin, input int arm_mid,
                     input int stop_after, output int n);
    int t, exp_auto, exp_n, limit, a;
    bit hit;
    for (int i = 0; i < MAXN; i++)
      s[i] = (mode == 0) ? i % 256 :
             (mode == 1) ? 50 : int'($urandom_range(0, 255));
    t = -1;
    exp_auto = 0;
    for (int i = PRE; i < MAXN; i++) begin
      hit = slope ? (s[i-1] > lvl && s[i] <= lvl)
                  : (s[i-1] < lvl && s[i] >= lvl);
      if (hit) begin
        t = i;
        break;
      end
      if (am != 0 && i - PRE + 1 == AUTO_TO) begin
        t = i;
        exp_auto = 1;
        break;
      end
    end
    exp_n = (t < 0) ? MAXN : t + DEPTH - PRE;
    limit = (stop_after > 0) ? stop_after : exp_n;
    trig_level = DW'(lvl);
    trig_slope = slope[0];
    auto_mode  = am[0];
    arm = 1'b1;
    if (coin != 0) begin
      sample_en = 1'b1;
      adc_data  = 8'hEE;
    end
    @(negedge clk_in);
    arm = 1'b0;
    sample_en = 1'b0;
    chk({tag, "_arm_busy"}, 32'(busy), 1);
    chk({tag, "_arm_done"}, 32'(done), 0);
    chk({tag, "_arm_auto"}, 32'(auto_trig), 0);
    n = 0;
    while (n < limit && !done) begin
      if (arm_mid != 0 && n == PRE + 5) arm = 1'b1;
      strobe(s[n], int'($urandom_range(0, gapmax)));
      arm = 1'b0;
      n++;
    end
    if (stop_after > 0) begin
      chk({tag, "_part_busy"}, 32'(busy), 1);
      return;
    end
    if (t < 0) begin
      chk({tag, "_hold_busy"}, 32'(busy), 1);
      chk({tag, "_hold_done"}, 32'(done), 0);
      return;
    end
    chk({tag, "_nstrobe"}, n, exp_n);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_auto"}, 32'(auto_trig), exp_auto);
    rd_chk({tag, "_rd_pre"}, PRE, s[t]);
    rd_chk({tag, "_rd_pre1"}, PRE - 1, s[t-1]);
    rd_chk({tag, "_rd_0"}, 0, s[t-PRE]);
    rd_chk({tag, "_rd_last"}, DEPTH - 1, s[t-PRE+DEPTH-1]);
    repeat (6) begin
      a = int'($urandom_range(0, DEPTH - 1));
      rd_chk({tag, "_rd_rand"}, a, s[t-PRE+a]);
    end
  endtask

  task automatic reset_chk(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_auto"}, 32'(auto_trig), 0);
    chk({tag, "_rd"}, 32'(rd_data), 0);
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst0_busy", 32'(busy), 0);
    chk("rst0_done", 32'(done), 0);
    chk("rst0_auto", 32'(auto_trig), 0);
    chk("rst0_rd", 32'(rd_data), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);

    run("rise", 0, 100, 0, 0, 3, 0, 0, 0, nstr);
    chk("rise_n292", nstr, 292);
    rd_chk("rise_64", 64, 100);
    rd_chk("rise_63", 63, 99);
    rd_chk("rise_0", 0, 36);
    rd_chk("rise_255", 255, 35);

    run("prewin", 0, 10, 0, 0, 3, 0, 0, 0, nstr);
    rd_chk("prewin_64", 64, 10);
    rd_chk("prewin_0", 0, 202);

    run("auto", 1, 100, 1, 1, 0, 0, 0, 0, nstr);
    chk("auto_n", nstr, PRE + AUTO_TO + 191);
    chk("auto_flag", 32'(auto_trig), 1);
    rd_chk("auto_rd", 17, 50);

    run("noauto", 1, 100, 1, 0, 0, 0, 0, 0, nstr);
    chk("noauto_n", nstr, MAXN);
    reset_chk("rst_hold");

    run("armmid", 0, 100, 0, 0, 1, 0, 1, 0, nstr);
    run("coin", 0, 100, 0, 0, 2, 1, 0, 0, nstr);
    rd_chk("coin_0", 0, 36);

    rd_addr = AW'(64);
    @(negedge clk_in);
    run("part", 0, 100, 0, 0, 1, 0, 0, 150, nstr);
    reset_chk("rst_post");
    run("rearm", 0, 100, 0, 0, 3, 0, 0, 0, nstr);
    chk("rearm_n292", nstr, 292);
    rd_chk("rearm_64", 64, 100);
    rd_chk("rearm_0", 0, 36);

    repeat (6) begin
      run("rand", 2, int'($urandom_range(20, 235)),
          int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 1)), 0, nstr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
